// File: rtl/idli_sqi_sram_m.sv
// ============================================================================
// Module   : idli_sqi_sram_m
// Brief    : Quad-SPI serial SRAM responder (READ 0x03 / WRITE 0x02, 24-bit
//            address, sequential mode, one dummy byte before read data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idli_sqi_sram_m #(
    parameter int ADDR_W = 10
) (
    input  logic              i_mem_gck,
    input  logic              i_mem_rst_n,
    input  logic              i_mem_sck,
    input  logic              i_mem_cs,
    input  logic [3:0]        i_mem_sio,
    output logic [3:0]        o_mem_sio,
    output logic              o_mem_sio_oe,
    input  logic              i_mem_bd_wr_en,
    input  logic [ADDR_W-1:0] i_mem_bd_addr,
    input  logic [7:0]        i_mem_bd_data
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
        S_DUMMY   = 3'd3,
        S_RD_DATA = 3'd4,
        S_WR_DATA = 3'd5,
        S_IGNORE  = 3'd6
    } state_t;

    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    state_t            r_state, w_state_nx;
    logic [2:0]        r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_is_rd, w_is_rd_nx;
    logic [3:0]        r_nib, w_nib_nx;
    logic              r_phase, w_phase_nx;
    logic [3:0]        r_sio, w_sio_nx;
    logic              r_oe, w_oe_nx;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_addr_inc = r_addr + 1'b1;

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_is_rd <= 1'b0;
            r_nib   <= 4'd0;
            r_phase <= 1'b0;
            r_sio   <= 4'd0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_addr  <= w_addr_nx;
            r_is_rd <= w_is_rd_nx;
            r_nib   <= w_nib_nx;
            r_phase <= w_phase_nx;
            r_sio   <= w_sio_nx;
            r_oe    <= w_oe_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_addr_nx  = r_addr;
        w_is_rd_nx = r_is_rd;
        w_nib_nx   = r_nib;
        w_phase_nx = r_phase;
        w_sio_nx   = r_sio;
        w_oe_nx    = r_oe;
        w_mem_we   = 1'b0;
        if (i_mem_cs) begin
            // Deselect aborts any transaction, including a half-written byte.
            w_state_nx = S_IDLE;
            w_cnt_nx   = 3'd0;
            w_phase_nx = 1'b0;
            w_oe_nx    = 1'b0;
        end else if (i_mem_sck) begin
            case (r_state)
                S_IDLE, S_CMD: begin
                    if (r_cnt == 3'd0) begin
                        w_nib_nx   = i_mem_sio;
                        w_cnt_nx   = 3'd1;
                        w_state_nx = S_CMD;
                    end else begin
                        w_cnt_nx = 3'd0;
                        if ({r_nib, i_mem_sio} == 8'h03) begin
                            w_state_nx = S_ADDR;
                            w_is_rd_nx = 1'b1;
                        end else if ({r_nib, i_mem_sio} == 8'h02) begin
                            w_state_nx = S_ADDR;
                            w_is_rd_nx = 1'b0;
                        end else begin
                            w_state_nx = S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    // Upper address bits fall off the top of the shifter.
                    w_addr_nx = ADDR_W'({r_addr, i_mem_sio});
                    if (r_cnt == 3'd5) begin
                        w_cnt_nx   = 3'd0;
                        w_phase_nx = 1'b0;
                        w_state_nx = r_is_rd ? S_DUMMY : S_WR_DATA;
                    end else begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
                S_DUMMY: begin
                    if (r_cnt == 3'd1) begin
                        w_cnt_nx   = 3'd0;
                        w_state_nx = S_RD_DATA;
                        w_sio_nx   = r_mem[r_addr][7:4];
                        w_oe_nx    = 1'b1;
                        w_phase_nx = 1'b0;
                    end else begin
                        w_cnt_nx = 3'd1;
                    end
                end
                S_RD_DATA: begin
                    if (!r_phase) begin
                        w_sio_nx   = r_mem[r_addr][3:0];
                        w_phase_nx = 1'b1;
                    end else begin
                        w_addr_nx  = w_addr_inc;
                        w_sio_nx   = r_mem[w_addr_inc][7:4];
                        w_phase_nx = 1'b0;
                    end
                end
                S_WR_DATA: begin
                    if (!r_phase) begin
                        w_nib_nx   = i_mem_sio;
                        w_phase_nx = 1'b1;
                    end else begin
                        w_mem_we   = 1'b1;
                        w_addr_nx  = w_addr_inc;
                        w_phase_nx = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = S_IGNORE;
                    w_oe_nx    = 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the serial write and backdoor are mutually
    // exclusive because one needs cs=0 and the other cs=1.
    always_ff @(posedge i_mem_gck) begin
        if (w_mem_we)
            r_mem[r_addr] <= {r_nib, i_mem_sio};
        else if (i_mem_bd_wr_en && i_mem_cs)
            r_mem[i_mem_bd_addr] <= i_mem_bd_data;
    end

    assign o_mem_sio    = r_sio;
    assign o_mem_sio_oe = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_sram_m.sv
// ============================================================================
// Module   : tb_idli_sqi_sram_m
// Brief    : Directed self-checking bench for the SQI SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idli_sqi_sram_m;

    localparam int ADDR_W = 10;

    logic              gck;
    logic              rst_n;
    logic              sck;
    logic              cs;
    logic [3:0]        sio_in;
    logic [3:0]        sio_out;
    logic              sio_oe;
    logic              bd_wr_en;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    int          n_vec;
    int          n_err;
    logic [15:0] nibs;
    logic        oe_ok;

    idli_sqi_sram_m #(.ADDR_W(ADDR_W)) dut (
        .i_mem_gck      (gck),
        .i_mem_rst_n    (rst_n),
        .i_mem_sck      (sck),
        .i_mem_cs       (cs),
        .i_mem_sio      (sio_in),
        .o_mem_sio      (sio_out),
        .o_mem_sio_oe   (sio_oe),
        .i_mem_bd_wr_en (bd_wr_en),
        .i_mem_bd_addr  (bd_addr),
        .i_mem_bd_data  (bd_data)
    );

    initial begin
        gck = 1'b0;
        forever #5 gck = ~gck;
    end

    task automatic send(input logic [3:0] n);
        @(negedge gck);
        cs     = 1'b0;
        sck    = 1'b1;
        sio_in = n;
        @(posedge gck);
        #1;
        sck = 1'b0;
    endtask

    task automatic end_txn();
        @(negedge gck);
        cs  = 1'b1;
        sck = 1'b0;
        @(posedge gck);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        send(cmd[7:4]);
        send(cmd[3:0]);
        for (int i = 5; i >= 0; i--) send(a[i*4 +: 4]);
    endtask

    task automatic bd_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge gck);
        cs       = 1'b1;
        bd_wr_en = 1'b1;
        bd_addr  = a;
        bd_data  = d;
        @(posedge gck);
        #1;
        bd_wr_en = 1'b0;
    endtask

    // Full read transaction; returns the nn data nibbles right-aligned.
    task automatic rd_txn(input logic [23:0] a, input int nn,
                          output logic [15:0] got, output logic ok);
        got = 16'h0;
        ok  = 1'b1;
        send_hdr(8'h03, a);
        send(4'h0);
        send(4'h0);
        for (int i = 0; i < nn; i++) begin
            if (i > 0) send(4'h0);
            got = {got[11:0], sio_out};
            if (sio_oe !== 1'b1) ok = 1'b0;
        end
        end_txn();
    endtask

    // Write transaction sending nn nibbles of d, high first.
    task automatic wr_txn(input logic [23:0] a, input logic [15:0] d, input int nn);
        send_hdr(8'h02, a);
        for (int i = 0; i < nn; i++) send(d[15-4*i -: 4]);
        end_txn();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sio_out !== 4'h0) begin
            n_err++;
            $display("FAIL reset_sio: got %h want 0", sio_out);
        end
        n_vec++;
        if (sio_oe !== 1'b0) begin
            n_err++;
            $display("FAIL reset_oe: got %b want 0", sio_oe);
        end
        repeat (2) @(negedge gck);
        rst_n = 1'b1;
    endtask

    task automatic test_preload_read();
        bd_wr(10'h010, 8'hA5);
        bd_wr(10'h011, 8'h3C);
        rd_txn(24'h000010, 4, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'hA53C || oe_ok !== 1'b1) begin
            n_err++;
            $display("FAIL preload_read: got %h oe_ok %b want a53c oe_ok 1", nibs, oe_ok);
        end
        n_vec++;
        if (sio_oe !== 1'b0) begin
            n_err++;
            $display("FAIL oe_after_cs: got %b want 0", sio_oe);
        end
        rd_txn(24'hFF0010, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h00A5) begin
            n_err++;
            $display("FAIL high_addr_ignored: got %h want 00a5", nibs);
        end
    endtask

    task automatic test_write_read();
        wr_txn(24'h000020, 16'h1234, 4);
        rd_txn(24'h000020, 4, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h1234 || oe_ok !== 1'b1) begin
            n_err++;
            $display("FAIL write_read: got %h oe_ok %b want 1234 oe_ok 1", nibs, oe_ok);
        end
    endtask

    task automatic test_wrap();
        wr_txn(24'h0003FF, 16'hEE77, 4);
        rd_txn(24'h000000, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h0077) begin
            n_err++;
            $display("FAIL wrap_write: got %h want 0077", nibs);
        end
        rd_txn(24'h0003FF, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h00EE) begin
            n_err++;
            $display("FAIL wrap_top_byte: got %h want 00ee", nibs);
        end
        rd_txn(24'h0003FF, 4, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'hEE77) begin
            n_err++;
            $display("FAIL wrap_read: got %h want ee77", nibs);
        end
    endtask

    task automatic test_unknown_cmd();
        logic [3:0] pat [0:19];
        logic       oe_seen;
        pat = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h9, 4'h9, 4'h9, 4'h9,
                4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
        oe_seen = 1'b0;
        send(4'hF);
        send(4'hF);
        for (int i = 0; i < 20; i++) begin
            send(pat[i]);
            if (sio_oe !== 1'b0) oe_seen = 1'b1;
        end
        end_txn();
        n_vec++;
        if (oe_seen !== 1'b0) begin
            n_err++;
            $display("FAIL unknown_cmd_oe: got oe_seen %b want 0", oe_seen);
        end
        rd_txn(24'h000010, 4, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'hA53C) begin
            n_err++;
            $display("FAIL unknown_cmd_storage: got %h want a53c", nibs);
        end
    endtask

    task automatic test_partial_write();
        wr_txn(24'h000020, 16'h9000, 1);
        rd_txn(24'h000020, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h0012) begin
            n_err++;
            $display("FAIL partial_write: got %h want 0012", nibs);
        end
    endtask

    task automatic test_reset_mid_read();
        send_hdr(8'h03, 24'h000010);
        send(4'h0);
        send(4'h0);
        n_vec++;
        if (sio_out !== 4'hA || sio_oe !== 1'b1) begin
            n_err++;
            $display("FAIL first_nibble: got %h oe %b want a oe 1", sio_out, sio_oe);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (sio_out !== 4'h0 || sio_oe !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_read: got %h oe %b want 0 oe 0", sio_out, sio_oe);
        end
        cs = 1'b1;
        @(negedge gck);
        rst_n = 1'b1;
        rd_txn(24'h000011, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h003C || oe_ok !== 1'b1) begin
            n_err++;
            $display("FAIL read_after_reset: got %h oe_ok %b want 003c oe_ok 1", nibs, oe_ok);
        end
    endtask

    task automatic test_hold();
        send_hdr(8'h03, 24'h000010);
        send(4'h0);
        send(4'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge gck);
            cs     = 1'b0;
            sck    = 1'b0;
            sio_in = 4'hF;
            @(posedge gck);
            #1;
            n_vec++;
            if (sio_out !== 4'hA || sio_oe !== 1'b1) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got %h oe %b want a oe 1", i, sio_out, sio_oe);
            end
        end
        send(4'h0);
        n_vec++;
        if (sio_out !== 4'h5) begin
            n_err++;
            $display("FAIL after_hold: got %h want 5", sio_out);
        end
        end_txn();
    endtask

    task automatic test_bd_while_cs0();
        @(negedge gck);
        cs       = 1'b0;
        sck      = 1'b0;
        bd_wr_en = 1'b1;
        bd_addr  = 10'h010;
        bd_data  = 8'h00;
        @(posedge gck);
        #1;
        bd_wr_en = 1'b0;
        end_txn();
        rd_txn(24'h000010, 2, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'h00A5) begin
            n_err++;
            $display("FAIL bd_while_cs0: got %h want 00a5", nibs);
        end
    endtask

    task automatic test_back_to_back();
        wr_txn(24'h000100, 16'hC3D4, 4);
        wr_txn(24'h000102, 16'h5E00, 2);
        rd_txn(24'h000101, 4, nibs, oe_ok);
        n_vec++;
        if (nibs !== 16'hD45E) begin
            n_err++;
            $display("FAIL back_to_back: got %h want d45e", nibs);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        cs       = 1'b1;
        sck      = 1'b0;
        sio_in   = 4'h0;
        bd_wr_en = 1'b0;
        bd_addr  = '0;
        bd_data  = 8'h00;
        test_reset();
        test_preload_read();
        test_write_read();
        test_wrap();
        test_unknown_cmd();
        test_partial_write();
        test_reset_mid_read();
        test_hold();
        test_bd_while_cs0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/idli_sqi_sram_m.md
# idli_sqi_sram_m

Synthesizable SQI (quad-SPI) SRAM responder: the memory-side end of the core's SQI memory interface, modelling a 23LC1024-style serial SRAM in sequential quad mode. One instance sits on each of the low and high memory buses. It is used in the bench and for FPGA bring-up, where no external SRAM exists. It decodes READ and WRITE commands and a 24-bit address, then streams byte data in nibbles, high nibble first.

## Interface
Parameters:
- ADDR_W, 10, log2 of the storage size in bytes. Address bits [23:ADDR_W] are ignored.

Ports:
- i_mem_gck  in  1  core clock; all state changes on the rising edge.
- i_mem_rst_n  in  1  asynchronous, active-low reset.
- i_mem_sck  in  1  serial clock from the initiator, treated as a per-cycle shift enable. A gck edge with sck=1 is one serial edge.
- i_mem_cs  in  1  chip select, active low.
- i_mem_sio  in  4  nibble from the initiator (slice_t).
- o_mem_sio  out  4  nibble to the initiator (slice_t).
- o_mem_sio_oe  out  1  high while the responder drives o_mem_sio.
- i_mem_bd_wr_en  in  1  backdoor byte write, used for bench preload.
- i_mem_bd_addr  in  ADDR_W  backdoor byte address.
- i_mem_bd_data  in  8  backdoor byte data.

## Operation
- Storage: 2^ADDR_W bytes. Reset does not clear storage.
- Serial edge: a gck edge with i_mem_cs=0 and i_mem_sck=1. Edges with sck=0 hold all state.
- States: IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
- IDLE:
  - When cs=1 in any state, the next edge goes to IDLE, clears the nibble counter, and sets oe=0.
  - While cs=0, IDLE behaves as CMD.
- CMD: takes 2 nibbles, high first.
  - At the second nibble: 0x03 goes to ADDR as a read. 0x02 goes to ADDR as a write. Any other value goes to IGNORE.
- ADDR: takes 6 nibbles, MSB first, into a 24-bit shift register.
  - At the sixth nibble: a read goes to DUMMY; a write goes to WR_DATA. The byte address is the low ADDR_W bits.
- DUMMY: takes 2 nibbles and ignores their values.
  - At the second nibble: go to RD_DATA, load o_mem_sio with mem[addr][7:4], set oe=1.
- RD_DATA: each serial edge advances the output by one nibble.
  - After the high nibble is presented, the edge loads mem[addr][3:0].
  - After the low nibble is presented, the edge sets addr = addr+1 mod 2^ADDR_W and loads the new high nibble.
- WR_DATA:
  - The first edge latches the high nibble.
  - The second edge writes {hi, i_mem_sio} to mem[addr] and increments addr with wrap.
  - A partial byte (cs rises after one nibble) is discarded.
- IGNORE: holds with oe=0 until cs=1.
- Backdoor:
  - Writes mem[bd_addr] on any edge where bd_wr_en=1 and cs=1.
  - Ignored while cs=0.
- Read after write: a byte committed on edge N is visible to a read issued in a later transaction.

## Timing
- Reset values: o_mem_sio=0, o_mem_sio_oe=0. State is IDLE, address register 0, nibble counter 0.
- All outputs are registered. Input-to-output change takes one gck edge.
- Read latency: 2 cmd + 6 addr + 2 dummy serial edges. The first data nibble is valid in the cycle after the 10th serial edge. Each later nibble is valid in the cycle after each following serial edge.
- o_mem_sio holds its value across edges with sck=0.
- oe falls in the cycle after cs is seen high. Reset mid-transaction has the same effect and also returns to IDLE.
- Wrap: the read or write address after 2^ADDR_W-1 is 0. No error is raised.
- cs=1 and sck=1 on the same edge: cs wins and nothing is shifted.

## Test plan
- Backdoor preload mem[0x010]=0xA5, mem[0x011]=0x3C. Serial READ: 0,3 / 0,0,0,0,1,0 / 2 dummy, then 4 data edges. Required: o_mem_sio = A,5,3,C, with oe=1 from the first data nibble.
- WRITE 0x02 to address 0x000020 with bytes 0x12, 0x34, then cs=1. READ the same address. Required: 1,2,3,4.
- Wrap with ADDR_W=10: WRITE 0xEE to 0x3FF and 0x77 to the next address. READ from 0x000. Required: 7,7. mem[0x3FF] reads back as E,E.
- Unknown command 0xFF followed by 20 serial edges. Required: oe stays 0 and storage is unchanged (check with a later read).
- Abort cases:
  - cs rises after one nibble of a write byte: the target byte keeps its old value.
  - Reset asserted mid-read: o_mem_sio=0 and oe=0 immediately, and the next transaction decodes correctly.
- Hold cases:
  - sck=0 for 5 cycles in mid-read: the nibble is held.
  - Backdoor write while cs=0: ignored.
